// File: rtl/pipe_skid_buffer.sv
// ---------------------------------------------------------------------------
// pipe_skid_buffer
//
// Two-entry elastic pipeline register with a valid/ready handshake on both
// sides. It holds data going forward and drives the stall upstream, so
// neighbouring stages that only have enable-gated registers can sit behind
// it. Under sustained flow it passes one item per cycle with no bubble.
// in_ready is decoded from the state register alone, which keeps the ready
// path cut at this register.
//
// Parameters:
//   WIDTH      payload width in bits (default 32)
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   flush      synchronous discard of every held entry
//   in_valid   upstream has data
//   in_ready   buffer can accept this cycle (function of state only)
//   in_data    upstream payload
//   out_valid  out_data is valid
//   out_ready  downstream accepts this cycle
//   out_data   downstream payload, always taken from the main register
//   stall_cnt  (only when PIPE_SKID_STALL_CNT_EN is defined) saturating
//              count of edges where upstream was valid but not accepted
//
// Build option:
//   PIPE_SKID_STALL_CNT_EN  adds the stall_cnt output and its counter.
//                           The core behaviour is the same in both builds.
// ---------------------------------------------------------------------------
module pipe_skid_buffer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
`ifdef PIPE_SKID_STALL_CNT_EN
    ,
    output logic [31:0]      stall_cnt
`endif
);

    // The fourth encoding (2'b11) is unreachable; the FSM sends it to EMPTY.
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        BUSY  = 2'b01,
        FULL  = 2'b10
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] main_q;
    logic [WIDTH-1:0] skid_q;
    logic             in_fire;
    logic             out_fire;

    assign out_valid = (state != EMPTY);
    assign in_ready  = (state != FULL);
    assign out_data  = main_q;

    assign in_fire  = in_valid  & in_ready;
    assign out_fire = out_valid & out_ready;

    // main_q is always the head of the queue and skid_q only ever holds the
    // second item, so promoting skid_q into main_q on a drain keeps FIFO
    // order. flush beats every handshake: an accepted-looking input is
    // dropped, while an output taken on the same edge counts as delivered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= EMPTY;
            main_q <= '0;
            skid_q <= '0;
        end else if (flush) begin
            state <= EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    if (in_fire) begin
                        main_q <= in_data;
                        state  <= BUSY;
                    end
                end
                BUSY: begin
                    if (in_fire && out_fire) begin
                        main_q <= in_data;
                    end else if (in_fire) begin
                        skid_q <= in_data;
                        state  <= FULL;
                    end else if (out_fire) begin
                        state <= EMPTY;
                    end
                end
                FULL: begin
                    // in_ready is low here, so only the drain side can move.
                    if (out_fire) begin
                        main_q <= skid_q;
                        state  <= BUSY;
                    end
                end
                default: begin
                    state <= EMPTY;
                end
            endcase
        end
    end

`ifdef PIPE_SKID_STALL_CNT_EN
    // Counts refused offers from upstream. It saturates instead of wrapping,
    // and it ignores flush so stall history survives a pipeline flush.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (in_valid && !in_ready && (stall_cnt != 32'hFFFF_FFFF)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_skid_buffer.sv
// ---------------------------------------------------------------------------
// tb_pipe_skid_buffer
//
// Scoreboard bench for pipe_skid_buffer. Each directed scenario pushes the
// words it expects to see delivered into a queue. A separate monitor pops
// one entry on every cycle where the DUT hands over an item. Words that must
// be dropped (flush, reset) are never pushed, so if they appear the monitor
// reports them. The stimulus process also checks state-visible outputs
// directly: in_ready, out_valid, out_data, and stall_cnt when it is built.
// Inputs change 1 time unit after the rising edge. The monitor samples on
// the falling edge.
// ---------------------------------------------------------------------------
module tb_pipe_skid_buffer;

    localparam int WIDTH = 32;

    logic             clk;
    logic             rst;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
`ifdef PIPE_SKID_STALL_CNT_EN
    logic [31:0]      stall_cnt;
`endif

    int               checks;
    int               failures;
    logic [WIDTH-1:0] exp_q[$];

    pipe_skid_buffer #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
`ifdef PIPE_SKID_STALL_CNT_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Every delivered word must match the head of the expected queue.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("[TB] FAIL unexpected_output got=%h required=none", out_data);
            end else begin
                logic [WIDTH-1:0] e;
                e = exp_q.pop_front();
                if (out_data !== e) begin
                    failures++;
                    $display("[TB] FAIL output_order got=%h required=%h", out_data, e);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic v, input logic [WIDTH-1:0] d,
                                 input logic ordy, input logic fl);
        in_valid  = v;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s got=%h required=%h", name, actual, expected);
        end
    endtask

    // Give the buffer a bounded number of cycles to deliver what is queued.
    task automatic drain(input string name);
        for (int i = 0; i < 20; i++) begin
            if (exp_q.size() == 0 && out_valid === 1'b0) break;
            step();
        end
        checkOutput(name, exp_q.size(), 0);
        checkOutput({name, "_idle"}, {31'd0, out_valid}, 32'd0);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        applyStimulus(1'b0, '0, 1'b0, 1'b0);

        // Values while reset is held.
        #2;
        checkOutput("reset_out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("reset_in_ready",  {31'd0, in_ready},  32'd1);
        checkOutput("reset_out_data",  out_data,           32'h0);
        #10;
        rst = 1'b0;
        step();

        // Streaming: three back-to-back words with no bubbles.
        exp_q.push_back(32'h11);
        exp_q.push_back(32'h22);
        exp_q.push_back(32'h33);
        applyStimulus(1'b1, 32'h11, 1'b1, 1'b0);
        step();
        checkOutput("stream_valid0", {31'd0, out_valid}, 32'd1);
        checkOutput("stream_ready0", {31'd0, in_ready},  32'd1);
        checkOutput("stream_data0",  out_data,           32'h11);
        applyStimulus(1'b1, 32'h22, 1'b1, 1'b0);
        step();
        checkOutput("stream_data1",  out_data,           32'h22);
        checkOutput("stream_ready1", {31'd0, in_ready},  32'd1);
        applyStimulus(1'b1, 32'h33, 1'b1, 1'b0);
        step();
        checkOutput("stream_data2",  out_data,           32'h33);
        checkOutput("stream_valid2", {31'd0, out_valid}, 32'd1);
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        drain("stream_drain");

        // Back-pressure: fill to FULL, hold a third word, then release.
        exp_q.push_back(32'hA0);
        exp_q.push_back(32'hA1);
        exp_q.push_back(32'hA2);
        applyStimulus(1'b1, 32'hA0, 1'b0, 1'b0);
        step();
        applyStimulus(1'b1, 32'hA1, 1'b0, 1'b0);
        step();
        checkOutput("bp_full_in_ready", {31'd0, in_ready}, 32'd0);
        checkOutput("bp_full_data",     out_data,          32'hA0);
        applyStimulus(1'b1, 32'hA2, 1'b0, 1'b0);
        step();
        step();
        checkOutput("bp_hold_data",     out_data,           32'hA0);
        checkOutput("bp_hold_valid",    {31'd0, out_valid}, 32'd1);
        checkOutput("bp_hold_in_ready", {31'd0, in_ready},  32'd0);
        applyStimulus(1'b1, 32'hA2, 1'b1, 1'b0);
        step();
        checkOutput("bp_promote_data",  out_data,          32'hA1);
        checkOutput("bp_promote_ready", {31'd0, in_ready}, 32'd1);
        step();
        checkOutput("bp_last_data", out_data, 32'hA2);
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        drain("bp_drain");

        // Simultaneous in/out while BUSY stays BUSY.
        exp_q.push_back(32'h55);
        exp_q.push_back(32'h66);
        applyStimulus(1'b1, 32'h55, 1'b0, 1'b0);
        step();
        applyStimulus(1'b1, 32'h66, 1'b1, 1'b0);
        step();
        checkOutput("busy_both_data",  out_data,           32'h66);
        checkOutput("busy_both_valid", {31'd0, out_valid}, 32'd1);
        checkOutput("busy_both_ready", {31'd0, in_ready},  32'd1);
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        drain("busy_drain");

        // Flush from FULL with a word offered. Nothing may come out afterward.
        applyStimulus(1'b1, 32'hB0, 1'b0, 1'b0);
        step();
        applyStimulus(1'b1, 32'hB1, 1'b0, 1'b0);
        step();
        applyStimulus(1'b1, 32'hB2, 1'b0, 1'b1);
        step();
        applyStimulus(1'b0, '0, 1'b0, 1'b0);
        checkOutput("flush_full_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("flush_full_ready", {31'd0, in_ready},  32'd1);
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        repeat (4) step();

        // Flush in BUSY: the outgoing word is delivered and the incoming one is dropped.
        exp_q.push_back(32'hC0);
        applyStimulus(1'b1, 32'hC0, 1'b0, 1'b0);
        step();
        applyStimulus(1'b1, 32'hC1, 1'b1, 1'b1);
        step();
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        checkOutput("flush_busy_valid", {31'd0, out_valid}, 32'd0);
        repeat (3) step();
        drain("flush_drain");

        // Asynchronous reset while FULL, part-way through a cycle.
        applyStimulus(1'b1, 32'hE0, 1'b0, 1'b0);
        step();
        applyStimulus(1'b1, 32'hE1, 1'b0, 1'b0);
        step();
        applyStimulus(1'b0, '0, 1'b0, 1'b0);
        checkOutput("pre_reset_in_ready", {31'd0, in_ready}, 32'd0);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("async_rst_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("async_rst_ready", {31'd0, in_ready},  32'd1);
        checkOutput("async_rst_data",  out_data,           32'h0);
        exp_q.delete();
        #2;
        rst = 1'b0;
        step();

        // Stall count: fill, then hold an offer for five FULL cycles and flush.
        applyStimulus(1'b1, 32'hD0, 1'b0, 1'b0);
        step();
        applyStimulus(1'b1, 32'hD1, 1'b0, 1'b0);
        step();
        applyStimulus(1'b1, 32'hD2, 1'b0, 1'b0);
        repeat (5) step();
        applyStimulus(1'b0, '0, 1'b0, 1'b0);
`ifdef PIPE_SKID_STALL_CNT_EN
        checkOutput("stall_cnt_five", stall_cnt, 32'd5);
`endif
        applyStimulus(1'b0, '0, 1'b0, 1'b1);
        step();
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        checkOutput("stall_flush_valid", {31'd0, out_valid}, 32'd0);
`ifdef PIPE_SKID_STALL_CNT_EN
        checkOutput("stall_cnt_after_flush", stall_cnt, 32'd5);
`endif
        repeat (3) step();
        checkOutput("final_queue_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
